bcd_scan_counter: RTL
=====================

# bcd_scan_counter

Parametrised successor to the three-digit encoder/brightness front panel. It holds a DIGITS-wide BCD up/down counter driven by a synchronised quadrature encoder. A time-multiplexed seven-segment scanner displays the count. A button-controlled PWM sets display/LED brightness. Everything runs on one clock with internal clock-enable dividers instead of separate scan/sample/PWM clocks, and it sits between the board pins and the panel.

## Interface
Parameters:
- DIGITS, 3: number of BCD digits (1..8).
- PWM_BITS, 4: PWM counter and duty width.
- SCAN_DIV, 1000: clk cycles per displayed digit (≥2).
- BTN_DIV, 500000: clk cycles between brightness button samples (≥2).

Ports. One clock; reset is asynchronous and active-high.
- clk, input, 1: sole clock.
- reset, input, 1: async active-high reset.
- quad_a, input, 1: raw encoder phase A, asynchronous.
- quad_b, input, 1: raw encoder phase B, asynchronous.
- led_brighter, input, 1: active-low button, asynchronous.
- led_dimmer, input, 1: active-low button, asynchronous.
- count_bcd, output, 4*DIGITS: BCD count; digit 0 is in bits [3:0].
- sel, output, $clog2(DIGITS) (min 1): binary index of the displayed digit; 0 is least significant.
- seg_digits, output, 7: {a,b,c,d,e,f,g}, active-low.
- pwm, output, 1: brightness PWM.
- en, output, 1: constant 1.
- en_n, output, 1: constant 0.

## Operation
- Synchronisers: quad_a, quad_b, led_brighter and led_dimmer each pass through a 2-flop synchroniser before use.
- Quadrature decoder: compares the previous and current synchronised {a,b}.
  - Gray sequence 00→01→11→10→00 gives up = 1 for one cycle.
  - The reverse sequence gives down = 1 for one cycle.
  - A double-bit change or no change gives no step.
- BCD counter: on up, add 1 with ripple carry; digit 9 becomes 0 and carries.
  - On down, subtract 1 with borrow; digit 0 becomes 9 and borrows.
  - Full wrap: all-9s + up → all-0s; all-0s + down → all-9s.
  - up and down are mutually exclusive by construction.
- Scanner: a divider counts 0..SCAN_DIV-1; at SCAN_DIV-1, sel advances. sel wraps from DIGITS-1 to 0.
  - seg_digits decodes digit[sel] combinationally from sel and count_bcd.
  - Codes 0–9 use the standard patterns (0 = 7'b0000001, 8 = 7'b0000000).
  - Codes 10–15 give 7'b1111111 (blank).
- Brightness: a divider produces btn_tick once every BTN_DIV cycles. On btn_tick:
  - brighter low, dimmer high: duty +1, saturating at 2^PWM_BITS-1.
  - dimmer low, brighter high: duty −1, saturating at 0.
  - both low or both high: duty holds.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-1. pwm = (pwm_cnt < duty).
  - duty 0 gives constant low.
  - duty max gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.

## Timing
- Reset values:
  - count_bcd = 0, sel = 0, and seg_digits = 7'b0000001.
  - duty = 2^(PWM_BITS-1), pwm_cnt = 0, and pwm = 0.
  - Both dividers are 0 and the synchroniser flops are 0.
  - en = 1 and en_n = 0 at all times.
- Quadrature latency: a pin edge reaches count_bcd 3 clk edges later (2 sync stages, 1 count update).
- Steps are accepted on back-to-back cycles; there is no rate limit.
- sel changes exactly every SCAN_DIV cycles. seg_digits follows sel or count_bcd in the same cycle.
- The duty change from btn_tick is visible in the pwm comparison on the next cycle. It is not deferred to the PWM period boundary.
- Reset asserted mid-scan or mid-PWM period forces all reset values immediately (async). Deassertion is used synchronously and is synchronised by the top level.

## Configuration
- BCD_SCAN_BLANK_EN defined: leading-zero digits are blanked (7'b1111111).
  - A digit is a leading zero if it is 0 and every more-significant digit is 0.
  - Digit 0 is never blanked, so a count of 0 shows a single "0".
- Not defined: all digits always display, including leading zeros.
- The macro does not affect count_bcd.

## Structure
- Shared package bcd_scan_pkg holds:
  - the seg7 constants (SEG_0..SEG_9, SEG_BLANK);
  - typedef bcd_digit_t (logic [3:0]);
  - a seg7 decode function.
- Sub-module quad_decoder: contains the 2-flop sync plus the transition table, and outputs up and down.

## Test plan
- Reset: assert reset mid-operation → count_bcd = 0, sel = 0, seg_digits = 7'b0000001, duty = 8, pwm = 0.
- Quadrature wrap: with DIGITS = 3, preload 999 via 999 forward steps; 1 more forward step → 000. 1 reverse step → 999. A glitch 00→11 → no change.
- Carry/borrow: at 099, step up → 100, with count_bcd[11:0] = 12'h100. Step down → 099.
- Scan: with SCAN_DIV = 4 and count 123, sel cycles 0,1,2,0 every 4 clks. seg_digits = SEG_3, SEG_2, SEG_1. Digit codes 10–15 are unreachable, so check blank via the package function.
- Brightness: hold brighter for 10 ticks from duty 8 → duty saturates at 15, pwm low 1 of 16 cycles. Hold both buttons → duty unchanged. Hold dimmer for 20 ticks → duty 0, pwm constantly low.
- Blanking: with BCD_SCAN_BLANK_EN and count 007, digits 2 and 1 = 7'b1111111 and digit 0 = SEG_7. Without the macro, digits 2 and 1 = SEG_0.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// Shared seven-segment constants, the BCD digit type and the digit-to-segment decoder.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package bcd_scan_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: 2-flop synchroniser on {a,b} plus a previous-state register;
// a single Gray step forward pulses up, a single step backward pulses down.
module quad_decoder (
  input  logic clk,
  input  logic reset,
  input  logic quad_a,
  input  logic quad_b,
  output logic up,
  output logic down
);

  logic [1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= {quad_a, quad_b};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Double-bit changes and idle both fall through to no step.
  always_comb begin
    up   = 1'b0;
    down = 1'b0;
    unique case ({prev_q, sync2_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up   = 1'b1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: down = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Encoder-driven BCD counter with multiplexed seven-segment scan and button-set PWM brightness.
// Define BCD_SCAN_BLANK_EN to blank leading-zero digits on the display.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BTN_DIV  = 500000,
  localparam int unsigned SelW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  quad_a,
  input  logic                  quad_b,
  input  logic                  led_brighter,
  input  logic                  led_dimmer,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [SelW-1:0]       sel,
  output logic [6:0]            seg_digits,
  output logic                  pwm,
  output logic                  en,
  output logic                  en_n
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned BtnW  = $clog2(BTN_DIV);
  localparam logic [PWM_BITS-1:0] DutyInit = PWM_BITS'(1 << (PWM_BITS - 1));

  logic                step_up, step_down;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [ScanW-1:0]    scan_div_q, scan_div_d;
  logic [BtnW-1:0]     btn_div_q, btn_div_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
  logic                pwm_q, pwm_d;
  logic [1:0]          btn_s1_q, btn_s2_q;  // {brighter, dimmer}, active-low
  logic                btn_tick;
  logic                carry, borrow;
  bcd_digit_t          digit, cur_digit;

  quad_decoder u_quad (
    .clk    (clk),
    .reset  (reset),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .up     (step_up),
    .down   (step_down)
  );

  // Ripple carry/borrow from digit 0 upward; a 9 (or 0) passes the carry on.
  always_comb begin
    count_d = count_q;
    carry   = step_up;
    borrow  = step_down;
    digit   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end else if (borrow) begin
        if (digit == 4'd0) begin
          count_d[4*i +: 4] = 4'd9;
        end else begin
          count_d[4*i +: 4] = digit - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    scan_div_d = scan_div_q + 1'b1;
    sel_d      = sel_q;
    if (scan_div_q == ScanW'(SCAN_DIV - 1)) begin
      scan_div_d = '0;
      sel_d      = (sel_q == SelW'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  always_comb begin
    btn_div_d = (btn_div_q == BtnW'(BTN_DIV - 1)) ? '0 : btn_div_q + 1'b1;
    btn_tick  = (btn_div_q == BtnW'(BTN_DIV - 1));
    duty_d    = duty_q;
    if (btn_tick) begin
      if (!btn_s2_q[1] && btn_s2_q[0] && (duty_q != '1)) begin
        duty_d = duty_q + 1'b1;
      end else if (btn_s2_q[1] && !btn_s2_q[0] && (duty_q != '0)) begin
        duty_d = duty_q - 1'b1;
      end
    end
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_d     = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      sel_q      <= '0;
      scan_div_q <= '0;
      btn_div_q  <= '0;
      duty_q     <= DutyInit;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      btn_s1_q   <= 2'b00;
      btn_s2_q   <= 2'b00;
    end else begin
      count_q    <= count_d;
      sel_q      <= sel_d;
      scan_div_q <= scan_div_d;
      btn_div_q  <= btn_div_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
      btn_s1_q   <= {led_brighter, led_dimmer};
      btn_s2_q   <= btn_s1_q;
    end
  end

`ifdef BCD_SCAN_BLANK_EN
  logic seen_nz, cur_blank;

  // Walk from the most significant digit; a digit is blank until a nonzero one has appeared.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    seen_nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (count_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (sel_q == SelW'(i)) begin
        cur_digit = count_q[4*i +: 4];
        cur_blank = !seen_nz && (i != 0);
      end
    end
  end

  assign seg_digits = cur_blank ? SEG_BLANK : seg7(cur_digit);
`else
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q == SelW'(i)) cur_digit = count_q[4*i +: 4];
    end
  end

  assign seg_digits = seg7(cur_digit);
`endif

  assign count_bcd = count_q;
  assign sel       = sel_q;
  assign pwm       = pwm_q;
  assign en        = 1'b1;
  assign en_n      = 1'b0;

endmodule
